// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline buffers.
//   stage_state_e : occupancy of a pipe_stage_buf (empty / main only / main + skid)
//   SKID_ON/OFF   : values for the SKID parameter of pipe_stage_buf
package pipe_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } stage_state_e;

    localparam bit SKID_ON  = 1'b1;
    localparam bit SKID_OFF = 1'b0;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter used for stage performance statistics.
//   clk, rst : clock, asynchronous active-high reset (clears the count)
//   inc      : add one this cycle
//   cnt      : current count, sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    // Hold at CNT_MAX so long stalls never read back as small numbers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline register between two core stages.
//   SKID=1 : two-entry skid buffer, full throughput, in_ready is a flop
//   SKID=0 : single entry, in_ready = !out_valid || out_ready
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and payload
//   flush                 : drop all held and incoming payloads
//   stall_cnt, bubble_cnt : saturating cycle counters (held-back / starved)
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter bit          SKID   = SKID_ON,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              in_ready_w;
    logic              out_valid_w;
    logic [DATA_W-1:0] out_data_w;

    if (SKID == SKID_ON) begin : g_skid

        stage_state_e      state_q;
        stage_state_e      state_d;
        logic [DATA_W-1:0] main_q;
        logic [DATA_W-1:0] skid_q;
        logic              in_ready_q;
        logic              in_hs;
        logic              out_hs;
        logic              main_load_in;
        logic              main_load_skid;
        logic              skid_load_in;

        assign in_hs  = in_valid && in_ready_q;
        assign out_hs = (state_q != S_EMPTY) && out_ready;

        // State register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= S_EMPTY;
            end else begin
                state_q <= state_d;
            end
        end

        // Next state and entry load enables; flush wins over everything
        always_comb begin
            state_d        = state_q;
            main_load_in   = 1'b0;
            main_load_skid = 1'b0;
            skid_load_in   = 1'b0;
            if (flush) begin
                state_d = S_EMPTY;
            end else begin
                unique case (state_q)
                    S_EMPTY: begin
                        if (in_hs) begin
                            state_d      = S_BUSY;
                            main_load_in = 1'b1;
                        end
                    end
                    S_BUSY: begin
                        if (in_hs && out_hs) begin
                            main_load_in = 1'b1;
                        end else if (in_hs) begin
                            state_d      = S_FULL;
                            skid_load_in = 1'b1;
                        end else if (out_hs) begin
                            state_d = S_EMPTY;
                        end
                    end
                    S_FULL: begin
                        if (out_hs) begin
                            state_d        = S_BUSY;
                            main_load_skid = 1'b1;
                        end
                    end
                    default: begin
                        state_d = S_EMPTY;
                    end
                endcase
            end
        end

        // in_ready looks at the next state so it never depends on out_ready combinationally
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                in_ready_q <= 1'b1;
            end else begin
                in_ready_q <= (state_d != S_FULL);
            end
        end

        // Payload storage; main only changes when empty or on an output handshake
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                main_q <= '0;
                skid_q <= '0;
            end else begin
                if (main_load_in) begin
                    main_q <= in_data;
                end else if (main_load_skid) begin
                    main_q <= skid_q;
                end
                if (skid_load_in) begin
                    skid_q <= in_data;
                end
            end
        end

        assign in_ready_w  = in_ready_q;
        assign out_valid_w = (state_q != S_EMPTY);
        assign out_data_w  = main_q;

    end else begin : g_reg

        stage_state_e      state_q;
        stage_state_e      state_d;
        logic [DATA_W-1:0] data_q;
        logic              ready_c;
        logic              in_hs;
        logic              out_hs;
        logic              data_load;

        // Free slot if empty or if the held entry leaves this cycle
        assign ready_c = (state_q == S_EMPTY) || out_ready;
        assign in_hs   = in_valid && ready_c;
        assign out_hs  = (state_q != S_EMPTY) && out_ready;

        // State register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= S_EMPTY;
            end else begin
                state_q <= state_d;
            end
        end

        // Next state; a simultaneous in/out handshake simply replaces the entry
        always_comb begin
            state_d   = state_q;
            data_load = 1'b0;
            if (flush) begin
                state_d = S_EMPTY;
            end else if (in_hs) begin
                state_d   = S_BUSY;
                data_load = 1'b1;
            end else if (out_hs) begin
                state_d = S_EMPTY;
            end
        end

        // Payload storage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q <= '0;
            end else if (data_load) begin
                data_q <= in_data;
            end
        end

        assign in_ready_w  = ready_c;
        assign out_valid_w = (state_q != S_EMPTY);
        assign out_data_w  = data_q;

    end

    assign in_ready  = in_ready_w;
    assign out_valid = out_valid_w;
    assign out_data  = out_data_w;

    // Performance counters keep running through flush
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid_w && !out_ready),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_ready && !out_valid_w),
        .cnt (bubble_cnt)
    );

endmodule : pipe_stage_buf

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench: one skid-mode and one single-register instance driven
// in lockstep, each compared every cycle against a queue-based model.
module tb_pipe_stage_buf;

    localparam int unsigned DW      = 8;
    localparam int unsigned CW      = 4;
    localparam int          CNT_MAX = 15;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          flush;

    logic          s_in_ready, s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [CW-1:0] s_stall, s_bubble;
    logic          r_in_ready, r_out_valid;
    logic [DW-1:0] r_out_data;
    logic [CW-1:0] r_stall, r_bubble;

    int n_tests;
    int n_fail;

    // Reference model: payload FIFOs (capacity 2 / 1) and counter values
    logic [DW-1:0] sq[$];
    logic [DW-1:0] rq[$];
    int s_stall_m, s_bubble_m, r_stall_m, r_bubble_m;

    pipe_stage_buf #(.DATA_W(DW), .SKID(1'b1), .CNT_W(CW)) u_skid (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .flush(flush), .stall_cnt(s_stall), .bubble_cnt(s_bubble)
    );

    pipe_stage_buf #(.DATA_W(DW), .SKID(1'b0), .CNT_W(CW)) u_reg (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(r_in_ready), .in_data(in_data),
        .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data),
        .flush(flush), .stall_cnt(r_stall), .bubble_cnt(r_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    // Compare both instances against the model (call away from clock edges)
    task automatic compare_all();
        check("s_in_ready",  32'(s_in_ready),  32'(sq.size() < 2));
        check("s_out_valid", 32'(s_out_valid), 32'(sq.size() > 0));
        if (sq.size() > 0) check("s_out_data", 32'(s_out_data), 32'(sq[0]));
        check("s_stall",  32'(s_stall),  32'(s_stall_m));
        check("s_bubble", 32'(s_bubble), 32'(s_bubble_m));
        check("r_in_ready",  32'(r_in_ready),  32'((rq.size() == 0) || out_ready));
        check("r_out_valid", 32'(r_out_valid), 32'(rq.size() > 0));
        if (rq.size() > 0) check("r_out_data", 32'(r_out_data), 32'(rq[0]));
        check("r_stall",  32'(r_stall),  32'(r_stall_m));
        check("r_bubble", 32'(r_bubble), 32'(r_bubble_m));
    endtask

    function automatic void model_reset();
        sq.delete();
        rq.delete();
        s_stall_m = 0; s_bubble_m = 0; r_stall_m = 0; r_bubble_m = 0;
    endfunction

    // One clock cycle: drive at negedge, check, then advance model at posedge
    task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic fl);
        bit s_in, s_out, r_in, r_out;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        compare_all();
        s_in  = iv && (sq.size() < 2);
        s_out = ordy && (sq.size() > 0);
        r_in  = iv && ((rq.size() == 0) || ordy);
        r_out = ordy && (rq.size() > 0);
        if (sq.size() > 0 && !ordy) s_stall_m  = sat_inc(s_stall_m);
        if (sq.size() == 0 && ordy) s_bubble_m = sat_inc(s_bubble_m);
        if (rq.size() > 0 && !ordy) r_stall_m  = sat_inc(r_stall_m);
        if (rq.size() == 0 && ordy) r_bubble_m = sat_inc(r_bubble_m);
        @(posedge clk);
        if (s_out) void'(sq.pop_front());
        if (s_in)  sq.push_back(id);
        if (fl)    sq.delete();
        if (r_out) void'(rq.pop_front());
        if (r_in)  rq.push_back(id);
        if (fl)    rq.delete();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        compare_all();
        check("s_out_data_rst", 32'(s_out_data), 32'h0);
        check("r_out_data_rst", 32'(r_out_data), 32'h0);
        rst = 1'b0;

        // Streaming 1..8 with out_ready high
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("stream_stall", 32'(s_stall), 32'h0);

        // Backpressure: 0xA, 0xB fill the skid buffer
        step(1'b1, 8'hA, 1'b0, 1'b0);
        step(1'b1, 8'hB, 1'b0, 1'b0);
        #1;
        check("bp_full_in_ready", 32'(s_in_ready), 32'h0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        #1;
        check("bp_stall", 32'(s_stall), 32'h4);
        check("bp_head", 32'(s_out_data), 32'hA);
        step(1'b0, '0, 1'b1, 1'b0);
        #1;
        check("bp_second", 32'(s_out_data), 32'hB);
        check("bp_ready_back", 32'(s_in_ready), 32'h1);
        repeat (2) step(1'b0, '0, 1'b1, 1'b0);

        // Flush together with an accept while holding 0x44
        step(1'b1, 8'h44, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b1);
        #1;
        check("flush_s_valid", 32'(s_out_valid), 32'h0);
        check("flush_s_ready", 32'(s_in_ready), 32'h1);
        check("flush_r_valid", 32'(r_out_valid), 32'h0);
        repeat (2) step(1'b0, '0, 1'b1, 1'b0);

        // Single-register: hold 0x7, then replace with 0x8 while delivering
        step(1'b1, 8'h7, 1'b0, 1'b0);
        #1;
        check("reg_held_ready", 32'(r_in_ready), 32'h0);
        check("reg_held_data", 32'(r_out_data), 32'h7);
        step(1'b1, 8'h8, 1'b1, 1'b0);
        #1;
        check("reg_replace", 32'(r_out_data), 32'h8);
        check("reg_replace_v", 32'(r_out_valid), 32'h1);

        // Bubble counter saturation
        repeat (20) step(1'b0, '0, 1'b1, 1'b0);
        #1;
        check("s_bubble_sat", 32'(s_bubble), 32'hF);
        check("r_bubble_sat", 32'(r_bubble), 32'hF);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
        end

        // Async reset while full with nonzero counters
        repeat (2) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 8'h1, 1'b0, 1'b0);
        step(1'b1, 8'h2, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        #2;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_s_valid", 32'(s_out_valid), 32'h0);
        check("arst_s_stall", 32'(s_stall), 32'h0);
        check("arst_s_bubble", 32'(s_bubble), 32'h0);
        check("arst_s_ready", 32'(s_in_ready), 32'h1);
        check("arst_r_valid", 32'(r_out_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h3, 1'b1, 1'b0);
        #1;
        check("post_rst_valid", 32'(s_out_valid), 32'h1);
        check("post_rst_data", 32'(s_out_data), 32'h3);
        step(1'b0, '0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipe_stage_buf

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised valid/ready pipeline register inserted between adjacent core stages (IFU→IDU, IDU→EXU, EXU→LSU, LSU→WB) as the core moves from a single-issue handshake chain to a true five-stage pipeline. It holds one stage's payload bundle and supports two modes:

- **Skid mode:** two-entry buffer, full throughput, registered `in_ready`.
- **Single-register mode:** one entry, cheaper.

It also supports a redirect flush and has built-in saturating stall and bubble counters for performance bring-up.

## Interface

Parameters:
- `DATA_W`, default 64: payload width in bits. Instances use stage bundle widths (64, 191, 108, …).
- `SKID`, default 1: 1 selects two-entry skid mode; 0 selects single-register mode.
- `CNT_W`, default 32: width of the performance counters.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  input  1: clock; all state updates on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `in_valid`  input  1: upstream has a payload.
- `in_ready`  output  1: block can accept a payload this cycle.
- `in_data`  input  DATA_W: upstream payload.
- `out_valid`  output  1: block presents a payload.
- `out_ready`  input  1: downstream accepts this cycle.
- `out_data`  output  DATA_W: payload presented downstream.
- `flush`  input  1: discard all held and incoming payloads (branch/trap redirect).
- `stall_cnt`  output  CNT_W: cycles with `out_valid && !out_ready`.
- `bubble_cnt`  output  CNT_W: cycles with `out_ready && !out_valid`.

## Operation

Handshakes:
- Input handshake occurs when `in_valid && in_ready`.
- Output handshake occurs when `out_valid && out_ready`.
- Payloads leave in acceptance order. No payload is duplicated or dropped, except by `flush` or `rst`.

Skid mode (`SKID=1`) state machine:
- States: `S_EMPTY` (no entries), `S_BUSY` (main entry valid), `S_FULL` (main and skid entries valid).
- `S_EMPTY`:
  - Input handshake → `S_BUSY`, with `in_data` written to main.
- `S_BUSY`:
  - Input and output handshake together → stay in `S_BUSY`; main is replaced by `in_data`.
  - Input handshake only → `S_FULL`; `in_data` is written to skid.
  - Output handshake only → `S_EMPTY`.
- `S_FULL`:
  - Output handshake → `S_BUSY`; skid moves to main. `in_ready` is 0 in `S_FULL`, so no input is accepted.
- Outputs:
  - `in_ready` is a register, equal to (next state != `S_FULL`). There is no combinational path from `out_ready` to `in_ready`.
  - `out_valid` = (state != `S_EMPTY`).
  - `out_data` = main entry.

Single-register mode (`SKID=0`):
- One entry only; `out_valid` = entry valid.
- `in_ready` = `!out_valid || out_ready` (combinational pass-through).
- Simultaneous input and output handshake replaces the entry.

Flush:
- `flush` high at an edge forces state to `S_EMPTY` (entry invalid) on the next cycle.
- `flush` has priority over any same-cycle input handshake; that payload is discarded.
- An output handshake in the flush cycle still counts as delivered downstream.
- In skid mode, `in_ready` is 1 in the cycle after a flush.
- Counters are not affected by `flush`.

Counters:
- Each counter increments by 1 on each qualifying cycle and saturates at all-ones (no wrap).
- Counting continues during `flush` cycles.

Data stability:
- `out_data` holds its value while `out_valid && !out_ready`.
- The main entry is written only when empty or on an output handshake.

## Timing

- Latency: a payload accepted at edge N is visible on `out_valid`/`out_data` after edge N (one cycle).
- Throughput: one payload per cycle in both modes when `out_ready` is held high.
- Reset values (asserted asynchronously, immediately):
  - state `S_EMPTY`;
  - `out_valid` 0, `out_data` 0;
  - `in_ready` 1 in skid mode (and in single-register mode, since the entry is invalid);
  - `stall_cnt` 0, `bubble_cnt` 0.
- Reset in mid-operation drops all entries at once and clears both counters. The first input handshake is possible at the first edge after `rst` deasserts.
- Skid mode bounds: at most 2 payloads held. `in_ready` falls in the cycle after the second entry fills, and rises in the cycle after a drain from `S_FULL`.

## Structure

- Shared package `pipe_pkg`:
  - typedef `stage_state_e` with `S_EMPTY`, `S_BUSY`, `S_FULL` (2-bit encoding);
  - localparam values `SKID_ON`/`SKID_OFF`.
- Sub-module `sat_counter` (params `W`; ports `clk`, `rst`, `inc`, `cnt`), instantiated twice for `stall_cnt` and `bubble_cnt`.
- Mode selection is by generate on `SKID`. Both mode branches share the port list and the counter logic.

## Test plan

- **Streaming:** `SKID=1`, `out_ready`=1, `in_valid`=1 with data 1..8 on consecutive cycles → `out_data` 1..8 on consecutive cycles starting one cycle later; `stall_cnt`=0.
- **Backpressure:** `SKID=1`, accept 0xA then 0xB while `out_ready`=0 → `in_ready`=0 in `S_FULL`. Release `out_ready` → 0xA then 0xB delivered in order; `stall_cnt` equals the number of held cycles.
- **Flush with accept:** `flush`=1 in the same cycle as `in_valid`, data 0x55, while holding 0x44 → next cycle `out_valid`=0, `in_ready`=1; neither 0x44 nor 0x55 ever appears at the output.
- **Single-register mode:** `SKID=0`, entry 0x7 held with `out_ready`=0 → `in_ready`=0. Raise `out_ready` together with `in_valid` (data 0x8) → 0x7 delivered and 0x8 present the next cycle.
- **Counter saturation:** `CNT_W`=4, `out_ready`=1, `in_valid`=0 for 20 cycles → `bubble_cnt` reaches 15 and stays at 15.
- **Async reset mid-operation:** in `S_FULL` with counters nonzero, assert `rst` between edges → `out_valid`=0 and counters 0 immediately; after deassert, data 0x3 is accepted and output one cycle later.
